// File: rtl/sync_fifo_pkg.sv
// Shared constants and flag helper for the sync_fifo block.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  // Pointers carry one extra wrap bit above the address bits. Empty when
  // they match exactly; full when only the wrap bit differs.
  function automatic fifo_flags_t calc_flags(input logic [31:0] wr_p,
                                             input logic [31:0] rd_p,
                                             input int unsigned ptr_w);
    fifo_flags_t flags;
    logic [31:0] diff;
    diff        = wr_p ^ rd_p;
    flags.empty = (diff == 32'd0);
    flags.full  = (diff == (32'd1 << ptr_w));
    return flags;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, registered read port.
// The read register is cleared by reset; the array itself is not.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Write port: store the incoming word when a write is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed word; hold the previous value otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Optional error pulses (overflow/underflow) are enabled by defining
// the macro SYNC_FIFO_ERR_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_op,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0] rd_ptr_reg, rd_ptr_next;
  logic           wr_accept;
  logic           rd_accept;
  fifo_flags_t    flags;

  // Flags come purely from the registered pointers.
  always_comb begin
    flags = calc_flags(32'(wr_ptr_reg), 32'(rd_ptr_reg), PTR_W);
    full  = flags.full;
    empty = flags.empty;
  end

  // Accept decisions and pointer advance; pointers wrap modulo 2*DEPTH.
  always_comb begin
    wr_accept   = wr_en && !full;
    rd_accept   = rd_en && !empty;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg[PTR_W-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_reg[PTR_W-1:0]),
    .rd_data (data_op)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  // One-cycle pulses flagging a rejected write or read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= wr_en && full;
      underflow_reg <= rd_en && empty;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=8, DEPTH=16).
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_op;
  logic       full;
  logic       empty;
`ifdef SYNC_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .data_op   (data_op),
    .full      (full),
    .empty     (empty)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    #2;
    // Reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data", 32'(data_op), 32'h00);
    tick();
    rst = 1'b1;
    tick();

    // Underflow from reset
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("uf_data", 32'(data_op), 32'h00);
    check("uf_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    check("uf_pulse", 32'(underflow), 32'd1);
`endif
    tick();
`ifdef SYNC_FIFO_ERR_EN
    check("uf_pulse_end", 32'(underflow), 32'd0);
`endif

    // Fill 0x01..0x10
    for (int i = 0; i < 15; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(i + 1);
      tick();
    end
    check("fill15_full", 32'(full), 32'd0);
    data_in = 8'h10;
    tick();
    wr_en = 1'b0;
    check("fill16_full", 32'(full), 32'd1);
    check("fill16_empty", 32'(empty), 32'd0);

    // Write while full is dropped
    wr_en   = 1'b1;
    data_in = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("ovf_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    check("ovf_pulse", 32'(overflow), 32'd1);
`endif
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("ovf_read", 32'(data_op), 32'h01);
    check("ovf_full_clr", 32'(full), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    check("ovf_pulse_end", 32'(overflow), 32'd0);
`endif

    // Refill, then simultaneous read+write while full
    wr_en   = 1'b1;
    data_in = 8'hCC;
    tick();
    check("refill_full", 32'(full), 32'd1);
    data_in = 8'hBB;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("simf_data", 32'(data_op), 32'h02);
    check("simf_full", 32'(full), 32'd0);

    // Drain: 0x03..0x10 then 0xCC; 0xBB must not appear
    for (int i = 0; i < 14; i++) begin
      rd_en = 1'b1;
      tick();
      check("drain", 32'(data_op), 32'(i + 3));
    end
    tick();
    check("drain_last", 32'(data_op), 32'hCC);
    rd_en = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd_empty_hold", 32'(data_op), 32'hCC);

    // Simultaneous with 3 stored
    wr_en = 1'b1;
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    data_in = 8'h33; tick();
    data_in = 8'h44;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("sim_data", 32'(data_op), 32'h11);
    check("sim_empty", 32'(empty), 32'd0);
    rd_en = 1'b1;
    tick(); check("sim_rd1", 32'(data_op), 32'h22);
    tick(); check("sim_rd2", 32'(data_op), 32'h33);
    tick(); check("sim_rd3", 32'(data_op), 32'h44);
    rd_en = 1'b0;
    check("sim_empty_end", 32'(empty), 32'd1);

    // Wrap: write 10 / read 10 / write 12 / read 12
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; data_in = 8'(8'h50 + i); tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1; tick();
      check("wrap_a", 32'(data_op), 32'(8'h50 + i));
    end
    rd_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; data_in = 8'(8'h50 + i); tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd_en = 1'b1; tick();
      check("wrap_b", 32'(data_op), 32'(8'h50 + i));
    end
    rd_en = 1'b0;
    check("wrap_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-stream with 5 stored
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = 8'(8'h70 + i); tick();
    end
    wr_en = 1'b0;
    check("pre_rst_empty", 32'(empty), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full", 32'(full), 32'd0);
    check("arst_data", 32'(data_op), 32'h00);
    tick();
    rst = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rst_rd", 32'(data_op), 32'h00);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
